// File: rtl/wallace_pkg.sv
// Shared constants and FSM encoding for the Wallace-tree final carry-propagate adder.
package wallace_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned SLICE  = 4;
  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wallace_cpa_if.sv
// Operand/result handshake bundle between the Wallace tree, the CPA and its consumer.
interface wallace_cpa_if #(
  parameter int unsigned WIDTH = wallace_pkg::WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_vec;
  logic [WIDTH-1:0] carry_vec;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] prod;
  logic             ovf;

  modport master (
    output in_valid, sum_vec, carry_vec, out_ready,
    input  in_ready, out_valid, prod, ovf
  );

  modport slave (
    input  in_valid, sum_vec, carry_vec, out_ready,
    output in_ready, out_valid, prod, ovf
  );
endinterface

// File: rtl/cpa_slice.sv
// Combinational SLICE-bit ripple-carry adder built from full adders.
module cpa_slice #(
  parameter int unsigned W = wallace_pkg::SLICE
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);
  logic [W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < W; g++) begin : g_fa
    assign o_sum[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]   = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[W];
endmodule

// File: rtl/wallace_cpa.sv
// Multi-cycle carry-propagate adder: resolves sum_vec + carry_vec one slice per cycle.
module wallace_cpa #(
  parameter int unsigned WIDTH = wallace_pkg::WIDTH,
  parameter int unsigned SLICE = wallace_pkg::SLICE
) (
  input  logic          clk,
  input  logic          rst_n,
  wallace_cpa_if.slave  bus
);
  import wallace_pkg::*;

  localparam int unsigned N_SLC    = WIDTH / SLICE;
  localparam int unsigned CNT_BITS = (N_SLC > 1) ? $clog2(N_SLC) : 1;

  if ((WIDTH % SLICE) != 0) begin : g_bad_param
    $error("wallace_cpa: WIDTH must be a multiple of SLICE");
  end

  state_t              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_prod;
  logic                r_ovf;
  logic                r_carry;
  logic [CNT_BITS-1:0] r_cnt;

  logic [SLICE-1:0]    w_a_slc;
  logic [SLICE-1:0]    w_b_slc;
  logic [SLICE-1:0]    w_sum_slc;
  logic                w_cout;

  // Counter-driven operand slice select; constant part-selects keep this a plain mux.
  always_comb begin
    w_a_slc = '0;
    w_b_slc = '0;
    for (int i = 0; i < int'(N_SLC); i++) begin
      if (r_cnt == CNT_BITS'(i)) begin
        w_a_slc = r_a[i*SLICE +: SLICE];
        w_b_slc = r_b[i*SLICE +: SLICE];
      end
    end
  end

  cpa_slice #(.W(SLICE)) u_slice (
    .i_a    (w_a_slc),
    .i_b    (w_b_slc),
    .i_cin  (r_carry),
    .o_sum  (w_sum_slc),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_prod      <= '0;
      r_ovf       <= 1'b0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // in_ready is registered, so the first post-reset edge only raises it.
          r_in_ready <= 1'b1;
          if (r_in_ready && bus.in_valid) begin
            r_a        <= bus.sum_vec;
            r_b        <= bus.carry_vec;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          for (int i = 0; i < int'(N_SLC); i++) begin
            if (r_cnt == CNT_BITS'(i)) r_prod[i*SLICE +: SLICE] <= w_sum_slc;
          end
          r_carry <= w_cout;
          if (r_cnt == CNT_BITS'(N_SLC - 1)) begin
            r_cnt       <= '0;
            r_ovf       <= w_cout;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_BITS'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.prod      = r_prod;
  assign bus.ovf       = r_ovf;
endmodule
